// File: rtl/apb_timer_slave.sv
// APB completer for an 8-bit up-counter timer (STATUS/GOAL/CURR registers).
// Define APB_TIMER_WAIT_EN to insert one wait state per access; undefined is zero-wait.
module apb_timer_slave #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int TICK_DIV  = 1
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] curr_q, curr_d;
    logic [DATA_W-1:0] goal_q, goal_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              irq_q;

    logic [ADDR_W-1:0] off;
    logic              mapped, is_status, is_goal, is_curr;
    logic              access, wr_acc, rd_acc, sts_wr, goal_wr;
    logic              tick, sts_hit;
    logic [DATA_W-1:0] curr_inc;

    assign off       = paddr - ADDR_W'(BASE_ADDR);
    assign mapped    = off < ADDR_W'(3);
    assign is_status = off == ADDR_W'(0);
    assign is_goal   = off == ADDR_W'(1);
    assign is_curr   = off == ADDR_W'(2);

`ifdef APB_TIMER_WAIT_EN
    // Set in the first ACCESS cycle, so pready rises in the second one; drops
    // after completion or whenever the bus leaves ACCESS.
    logic wait_q;
    always_ff @(posedge clk) begin
        if (preset) wait_q <= 1'b0;
        else        wait_q <= psel & penable & ~wait_q;
    end
    assign pready = psel & penable & wait_q & ~preset;
`else
    assign pready = psel & penable & ~preset;
`endif

    assign access  = pready;
    assign wr_acc  = access & pwrite;
    assign rd_acc  = access & ~pwrite;
    assign sts_wr  = wr_acc & is_status;
    assign goal_wr = wr_acc & is_goal;

    assign tick     = div_q == DIV_W'(TICK_DIV - 1);
    assign curr_inc = curr_q + DATA_W'(1);

    always_comb begin
        state_d = state_q;
        curr_d  = curr_q;
        div_d   = div_q;
        goal_d  = goal_wr ? pwdata : goal_q;
        sts_hit = 1'b0;

        if (sts_wr) begin
            if (pwdata[1]) begin
                if (state_q == ST_RUN) begin
                    state_d = ST_PAUSE;
                    sts_hit = 1'b1;
                end
            end else if (pwdata[0]) begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        state_d = ST_RUN;
                        curr_d  = '0;
                        div_d   = '0;
                        sts_hit = 1'b1;
                    end
                    ST_PAUSE: begin
                        state_d = ST_RUN;
                        sts_hit = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // A state-changing STATUS write preempts this cycle's count step.
        if (!sts_hit && state_q == ST_RUN) begin
            if (curr_q >= goal_q) begin
                state_d = ST_DONE;
            end else if (tick) begin
                div_d = '0;
                if (curr_inc >= goal_q) begin
                    curr_d  = goal_q;
                    state_d = ST_DONE;
                end else begin
                    curr_d = curr_inc;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            curr_q  <= '0;
            goal_q  <= '0;
            div_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            curr_q  <= curr_d;
            goal_q  <= goal_d;
            div_q   <= div_d;
            irq_q   <= state_d == ST_DONE;
        end
    end

    always_comb begin
        prdata = '0;
        if (rd_acc) begin
            if (is_status)    prdata = DATA_W'({state_q, 2'b00});
            else if (is_goal) prdata = goal_q;
            else if (is_curr) prdata = curr_q;
        end
    end

    assign pslverr = access & (~mapped | (pwrite & is_curr));
    assign irq     = irq_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Scoreboard bench for apb_timer_slave: expectations queued at issue, checked on pready.
module tb_apb_timer_slave;

`ifdef APB_TIMER_WAIT_EN
    localparam int XE  = 4;   // edges from one commit to the next back-to-back commit
    localparam int ACC = 2;   // ACCESS cycles per transfer
`else
    localparam int XE  = 3;
    localparam int ACC = 1;
`endif

    logic       clk = 1'b0;
    logic       preset = 1'b1;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [1:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr, irq;

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
        logic       rd;
    } exp_t;
    exp_t sb[$];

    apb_timer_slave dut (
        .clk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [1:0] a, input logic w,
                        input logic [7:0] wd, input logic [7:0] ed, input logic ee);
        exp_t e;
        int   n;
        bit   done;
        e.tag = tag; e.data = ed; e.err = ee; e.rd = ~w;
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        @(negedge clk);
        chk({tag, "_setup_rdy"}, pready, 0);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (pready) begin
                e = sb.pop_front();
                if (e.rd) chk({e.tag, "_data"}, prdata, e.data);
                chk({e.tag, "_err"}, pslverr, e.err);
                chk({e.tag, "_acc"}, n, ACC);
                done = 1;
            end else if (n > 8) begin
                e = sb.pop_front();
                chk({e.tag, "_timeout"}, 0, 1);
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        chk(tag, irq, 1);
    endtask

    initial begin
        int k;
        // reset with a GOAL write on the bus: must not complete or commit
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 2'd1; pwdata = 8'h77;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", prdata, 0);
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        preset = 1'b0;
        xfer("rd_status0", 2'd0, 0, 0, 8'h00, 0);
        xfer("rd_goal0",   2'd1, 0, 0, 8'h00, 0);

        xfer("wr_unmap", 2'd3, 1, 8'h55, 8'h00, 1);
        xfer("rd_unmap", 2'd3, 0, 0,     8'h00, 1);
        xfer("rd_goal_u", 2'd1, 0, 0, 8'h00, 0);
        xfer("rd_curr_u", 2'd2, 0, 0, 8'h00, 0);

        // SETUP held with a START write pending: nothing may happen
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 8'h01;
        repeat (4) @(negedge clk);
        chk("hold_pready", pready, 0);
        @(posedge clk); #1;
        psel = 1'b0; pwrite = 1'b0;
        xfer("rd_status_hold", 2'd0, 0, 0, 8'h00, 0);

        // full run to GOAL=25
        xfer("wr_goal25", 2'd1, 1, 8'd25, 0, 0);
        xfer("rd_goal25", 2'd1, 0, 0, 8'd25, 0);
        xfer("start1", 2'd0, 1, 8'h01, 0, 0);
        xfer("rd_curr_early", 2'd2, 0, 0, 8'(XE - 1), 0);
        xfer("rd_status_run", 2'd0, 0, 0, 8'h04, 0);
        chk("irq_running", irq, 0);
        wait_irq("irq_done1");
        xfer("rd_status_done", 2'd0, 0, 0, 8'h08, 0);
        xfer("rd_curr_done", 2'd2, 0, 0, 8'd25, 0);

        // pause (STOP beats START) then resume
        xfer("start2", 2'd0, 1, 8'h01, 0, 0);
        repeat (10) @(posedge clk);
        xfer("stop", 2'd0, 1, 8'h03, 0, 0);
        k = 9 + XE;
        xfer("rd_status_pause", 2'd0, 0, 0, 8'h0C, 0);
        xfer("rd_curr_pause_a", 2'd2, 0, 0, 8'(k), 0);
        xfer("rd_curr_pause_b", 2'd2, 0, 0, 8'(k), 0);
        chk("irq_paused", irq, 0);
        xfer("resume", 2'd0, 1, 8'h01, 0, 0);
        xfer("rd_curr_resume", 2'd2, 0, 0, 8'(k + XE - 1), 0);
        wait_irq("irq_done2");
        xfer("rd_curr_done2", 2'd2, 0, 0, 8'd25, 0);

        // CURR is read-only
        xfer("wr_curr", 2'd2, 1, 8'h10, 0, 1);
        xfer("rd_curr_ro", 2'd2, 0, 0, 8'd25, 0);

        // lowering GOAL below CURR mid-run completes without moving CURR
        xfer("start3", 2'd0, 1, 8'h01, 0, 0);
        repeat (10) @(posedge clk);
        xfer("wr_goal5", 2'd1, 1, 8'd5, 0, 0);
        xfer("rd_status_lg", 2'd0, 0, 0, 8'h08, 0);
        xfer("rd_curr_lg", 2'd2, 0, 0, 8'(10 + XE), 0);
        chk("irq_lg", irq, 1);

        // GOAL==0 completes immediately with CURR=0
        xfer("wr_goal0", 2'd1, 1, 8'd0, 0, 0);
        xfer("start4", 2'd0, 1, 8'h01, 0, 0);
        xfer("rd_status_g0", 2'd0, 0, 0, 8'h08, 0);
        xfer("rd_curr_g0", 2'd2, 0, 0, 8'h00, 0);

        // reset again clears everything
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        @(negedge clk);
        chk("rst2_irq", irq, 0);
        xfer("rd_status_rst2", 2'd0, 0, 0, 8'h00, 0);
        xfer("rd_curr_rst2", 2'd2, 0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
